// File: rtl/truncate_sequencer.sv
`default_nettype none
// ---- truncate_sequencer: frame/phase sequencer for the truncation datapath -- rev 1.0 ----

module truncate_sequencer #(
  parameter int MXPHASE = 8,
  parameter int CNTW    = 16
) (
  input  logic            clock,
  input  logic            global_reset_n,
  input  logic            enable,
  input  logic [3:0]      delay,
  input  logic            resync,
  input  logic            vpfs_any,
  input  logic            cluster_valid,
  output logic            latch_en,
  output logic [3:0]      phase,
  output logic [1:0]      state,
  output logic [4:0]      cluster_count,
  output logic            overflow,
  output logic [CNTW-1:0] overflow_cnt,
  output logic [CNTW-1:0] frame_cnt
);

  localparam logic [1:0]      ST_IDLE    = 2'd0;
  localparam logic [1:0]      ST_DELAY   = 2'd1;
  localparam logic [1:0]      ST_RUN     = 2'd2;
  localparam logic [3:0]      LAST_PHASE = 4'(MXPHASE - 1);
  localparam logic [4:0]      CLUST_MAX  = 5'd31;
  localparam logic [CNTW-1:0] OVF_MAX    = '1;
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);

  logic [1:0]      state_next;
  logic [3:0]      dcnt;
  logic [3:0]      dcnt_next;
  logic [3:0]      phase_next;
  logic            latch_en_next;
  logic [4:0]      cnt;
  logic [4:0]      cnt_next;
  logic [4:0]      cluster_count_next;
  logic            overflow_next;
  logic [CNTW-1:0] overflow_cnt_next;
  logic [CNTW-1:0] frame_cnt_next;
  logic [4:0]      frame_total;
  logic            frame_end;
  logic            partial_end;

  // Running total including this cycle's cluster, saturating at 31.
  assign frame_total = (cluster_valid && (cnt != CLUST_MAX)) ? cnt + 5'd1 : cnt;
  assign frame_end   = (state == ST_RUN) && enable && (phase == LAST_PHASE);
  // A resync landing on the frame end is folded into that frame end.
  assign partial_end = (state == ST_RUN) && enable && resync && !frame_end;

  // State register
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_DELAY;
      end
      ST_DELAY: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (!resync && (dcnt == 4'd0)) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    dcnt_next          = dcnt;
    phase_next         = 4'd0;
    latch_en_next      = 1'b0;
    cnt_next           = cnt;
    cluster_count_next = cluster_count;
    overflow_next      = 1'b0;
    overflow_cnt_next  = overflow_cnt;
    frame_cnt_next     = frame_cnt;
    case (state)
      ST_IDLE: begin
        cnt_next = 5'd0;
        if (enable) dcnt_next = delay;
      end
      ST_DELAY: begin
        cnt_next      = 5'd0;
        latch_en_next = (state_next == ST_RUN);
        if (!enable) begin
          dcnt_next = 4'd0;
        end else if (resync) begin
          dcnt_next = delay;
        end else if (dcnt != 4'd0) begin
          dcnt_next = dcnt - 4'd1;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          cnt_next = 5'd0;
        end else if (frame_end || partial_end) begin
          cnt_next           = 5'd0;
          cluster_count_next = frame_total;
          frame_cnt_next     = frame_cnt + CNT_ONE;
          latch_en_next      = 1'b1;
          if (frame_end && vpfs_any) begin
            overflow_next = 1'b1;
            if (overflow_cnt != OVF_MAX) overflow_cnt_next = overflow_cnt + CNT_ONE;
          end
        end else begin
          cnt_next   = frame_total;
          phase_next = phase + 4'd1;
        end
      end
      default: begin
        cnt_next  = 5'd0;
        dcnt_next = 4'd0;
      end
    endcase
  end

  // Registered outputs and internal counters
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      dcnt          <= 4'd0;
      phase         <= 4'd0;
      latch_en      <= 1'b0;
      cnt           <= 5'd0;
      cluster_count <= 5'd0;
      overflow      <= 1'b0;
      overflow_cnt  <= '0;
      frame_cnt     <= '0;
    end else begin
      dcnt          <= dcnt_next;
      phase         <= phase_next;
      latch_en      <= latch_en_next;
      cnt           <= cnt_next;
      cluster_count <= cluster_count_next;
      overflow      <= overflow_next;
      overflow_cnt  <= overflow_cnt_next;
      frame_cnt     <= frame_cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_truncate_sequencer.sv
`default_nettype none
// ---- tb_truncate_sequencer: directed bench for truncate_sequencer (MXPHASE=8, CNTW=16) -- rev 1.0 ----

module tb_truncate_sequencer;

  logic        clock;
  logic        global_reset_n;
  logic        enable;
  logic [3:0]  delay;
  logic        resync;
  logic        vpfs_any;
  logic        cluster_valid;
  logic        latch_en;
  logic [3:0]  phase;
  logic [1:0]  state;
  logic [4:0]  cluster_count;
  logic        overflow;
  logic [15:0] overflow_cnt;
  logic [15:0] frame_cnt;

  int compared;
  int mismatched;

  truncate_sequencer #(.MXPHASE(8), .CNTW(16)) dut (
    .clock         (clock),
    .global_reset_n(global_reset_n),
    .enable        (enable),
    .delay         (delay),
    .resync        (resync),
    .vpfs_any      (vpfs_any),
    .cluster_valid (cluster_valid),
    .latch_en      (latch_en),
    .phase         (phase),
    .state         (state),
    .cluster_count (cluster_count),
    .overflow      (overflow),
    .overflow_cnt  (overflow_cnt),
    .frame_cnt     (frame_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    global_reset_n = 1'b0; enable = 1'b1; delay = 4'd0; resync = 1'b0; vpfs_any = 1'b0; cluster_valid = 1'b0;
    #1;
    compared++; if (state !== 2'd0) begin mismatched++; $display("FAIL reset_state: got %0d expected 0", state); end
    compared++; if (latch_en !== 1'b0) begin mismatched++; $display("FAIL reset_latch_en: got %0d expected 0", latch_en); end
    compared++; if (phase !== 4'd0) begin mismatched++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    compared++; if (cluster_count !== 5'd0) begin mismatched++; $display("FAIL reset_cluster_count: got %0d expected 0", cluster_count); end
    compared++; if (overflow !== 1'b0 || overflow_cnt !== 16'd0 || frame_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_counters: got ovf=%0d ovf_cnt=%0d frame_cnt=%0d expected all 0", overflow, overflow_cnt, frame_cnt); end
    enable = 1'b0;
    #1 global_reset_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    compared++; if (state !== 2'd0) begin mismatched++; $display("FAIL idle_hold_state: got %0d expected 0", state); end
  endtask

  task automatic test_startup();
    logic       exp_latch;
    logic [1:0] exp_state;
    logic [3:0] exp_phase;
    delay = 4'd3; enable = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      cluster_valid = (k <= 5);
      step();
      exp_latch = (k == 5) || (k == 13);
      exp_state = (k <= 4) ? 2'd1 : 2'd2;
      exp_phase = (k < 5) ? 4'd0 : 4'((k - 5) % 8);
      compared++; if (latch_en !== exp_latch) begin mismatched++; $display("FAIL startup_latch_en k=%0d: got %0d expected %0d", k, latch_en, exp_latch); end
      compared++; if (state !== exp_state) begin mismatched++; $display("FAIL startup_state k=%0d: got %0d expected %0d", k, state, exp_state); end
      compared++; if (phase !== exp_phase) begin mismatched++; $display("FAIL startup_phase k=%0d: got %0d expected %0d", k, phase, exp_phase); end
    end
    compared++; if (frame_cnt !== 16'd1) begin mismatched++; $display("FAIL startup_frame_cnt: got %0d expected 1", frame_cnt); end
    compared++; if (cluster_count !== 5'd0) begin mismatched++; $display("FAIL startup_cluster_ignored: got %0d expected 0", cluster_count); end
  endtask

  task automatic test_cluster_count();
    logic [7:0] pat;
    pat = 8'b1010_1101;
    for (int p = 0; p < 8; p++) begin
      cluster_valid = pat[p];
      step();
    end
    cluster_valid = 1'b0;
    compared++; if (cluster_count !== 5'd5) begin mismatched++; $display("FAIL cluster_count: got %0d expected 5", cluster_count); end
    compared++; if (frame_cnt !== 16'd2) begin mismatched++; $display("FAIL cluster_frame_cnt: got %0d expected 2", frame_cnt); end
    compared++; if (overflow !== 1'b0 || overflow_cnt !== 16'd0) begin mismatched++; $display("FAIL cluster_no_overflow: got ovf=%0d ovf_cnt=%0d expected 0/0", overflow, overflow_cnt); end
    compared++; if (latch_en !== 1'b1 || phase !== 4'd0) begin mismatched++; $display("FAIL cluster_wrap: got latch=%0d phase=%0d expected 1/0", latch_en, phase); end
  endtask

  task automatic test_overflow();
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 8; p++) begin
        vpfs_any = (p == 7);
        step();
        compared++; if (overflow !== (p == 7)) begin mismatched++; $display("FAIL overflow_pulse f=%0d p=%0d: got %0d expected %0d", f, p, overflow, (p == 7)); end
      end
    end
    vpfs_any = 1'b0;
    compared++; if (overflow_cnt !== 16'd3) begin mismatched++; $display("FAIL overflow_cnt: got %0d expected 3", overflow_cnt); end
    compared++; if (frame_cnt !== 16'd5) begin mismatched++; $display("FAIL overflow_frame_cnt: got %0d expected 5", frame_cnt); end
  endtask

  task automatic test_resync();
    logic [2:0] pat;
    pat = 3'b011;
    for (int p = 0; p < 3; p++) begin
      cluster_valid = pat[p];
      step();
    end
    compared++; if (phase !== 4'd3) begin mismatched++; $display("FAIL resync_pre_phase: got %0d expected 3", phase); end
    cluster_valid = 1'b1; resync = 1'b1; vpfs_any = 1'b1;
    step();
    cluster_valid = 1'b0; resync = 1'b0; vpfs_any = 1'b0;
    compared++; if (latch_en !== 1'b1 || phase !== 4'd0) begin mismatched++; $display("FAIL resync_realign: got latch=%0d phase=%0d expected 1/0", latch_en, phase); end
    compared++; if (cluster_count !== 5'd3) begin mismatched++; $display("FAIL resync_partial_count: got %0d expected 3", cluster_count); end
    compared++; if (overflow !== 1'b0 || overflow_cnt !== 16'd3) begin mismatched++; $display("FAIL resync_no_overflow: got ovf=%0d ovf_cnt=%0d expected 0/3", overflow, overflow_cnt); end
    compared++; if (frame_cnt !== 16'd6) begin mismatched++; $display("FAIL resync_frame_cnt: got %0d expected 6", frame_cnt); end
  endtask

  task automatic test_resync_at_frame_end();
    for (int p = 0; p < 7; p++) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    compared++; if (frame_cnt !== 16'd7 || phase !== 4'd0 || latch_en !== 1'b1) begin mismatched++; $display("FAIL resync_end_single: got frame_cnt=%0d phase=%0d latch=%0d expected 7/0/1", frame_cnt, phase, latch_en); end
    step();
    compared++; if (frame_cnt !== 16'd7 || phase !== 4'd1) begin mismatched++; $display("FAIL resync_end_after: got frame_cnt=%0d phase=%0d expected 7/1", frame_cnt, phase); end
  endtask

  task automatic test_disable_priority();
    cluster_valid = 1'b1;
    for (int p = 0; p < 4; p++) step();
    compared++; if (phase !== 4'd5) begin mismatched++; $display("FAIL disable_pre_phase: got %0d expected 5", phase); end
    enable = 1'b0; resync = 1'b1;
    step();
    resync = 1'b0;
    compared++; if (state !== 2'd0 || latch_en !== 1'b0 || phase !== 4'd0) begin mismatched++; $display("FAIL disable_idle: got state=%0d latch=%0d phase=%0d expected 0/0/0", state, latch_en, phase); end
    compared++; if (frame_cnt !== 16'd7 || cluster_count !== 5'd0 || overflow_cnt !== 16'd3) begin mismatched++; $display("FAIL disable_hold: got frame_cnt=%0d cc=%0d ovf_cnt=%0d expected 7/0/3", frame_cnt, cluster_count, overflow_cnt); end
    step(); step();
    compared++; if (state !== 2'd0 || latch_en !== 1'b0) begin mismatched++; $display("FAIL disable_stay: got state=%0d latch=%0d expected 0/0", state, latch_en); end
    cluster_valid = 1'b0; delay = 4'd0; enable = 1'b1;
    step();
    compared++; if (state !== 2'd1) begin mismatched++; $display("FAIL delay0_delay: got %0d expected 1", state); end
    step();
    compared++; if (state !== 2'd2 || latch_en !== 1'b1 || phase !== 4'd0) begin mismatched++; $display("FAIL delay0_run: got state=%0d latch=%0d phase=%0d expected 2/1/0", state, latch_en, phase); end
    for (int p = 0; p < 8; p++) step();
    compared++; if (cluster_count !== 5'd0 || frame_cnt !== 16'd8) begin mismatched++; $display("FAIL disable_count_cleared: got cc=%0d frame_cnt=%0d expected 0/8", cluster_count, frame_cnt); end
  endtask

  task automatic test_delay_resync();
    enable = 1'b0;
    step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    compared++; if (state !== 2'd0) begin mismatched++; $display("FAIL idle_resync_ignored: got %0d expected 0", state); end
    delay = 4'd2; enable = 1'b1;
    step();
    step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    step();
    compared++; if (state !== 2'd1) begin mismatched++; $display("FAIL delay_reload_a: got %0d expected 1", state); end
    step();
    compared++; if (state !== 2'd1) begin mismatched++; $display("FAIL delay_reload_b: got %0d expected 1", state); end
    step();
    compared++; if (state !== 2'd2 || latch_en !== 1'b1) begin mismatched++; $display("FAIL delay_reload_run: got state=%0d latch=%0d expected 2/1", state, latch_en); end
  endtask

  task automatic test_async_reset();
    cluster_valid = 1'b1;
    for (int p = 0; p < 3; p++) step();
    #2 global_reset_n = 1'b0;
    #1;
    compared++; if (state !== 2'd0 || phase !== 4'd0 || latch_en !== 1'b0) begin mismatched++; $display("FAIL async_reset_fsm: got state=%0d phase=%0d latch=%0d expected 0/0/0", state, phase, latch_en); end
    compared++; if (cluster_count !== 5'd0 || overflow !== 1'b0 || overflow_cnt !== 16'd0 || frame_cnt !== 16'd0) begin mismatched++; $display("FAIL async_reset_counters: got cc=%0d ovf=%0d ovf_cnt=%0d frame_cnt=%0d expected 0", cluster_count, overflow, overflow_cnt, frame_cnt); end
    cluster_valid = 1'b0; delay = 4'd1; enable = 1'b1;
    #1 global_reset_n = 1'b1;
    step();
    step();
    compared++; if (state !== 2'd1) begin mismatched++; $display("FAIL restart_delay: got %0d expected 1", state); end
    step();
    compared++; if (state !== 2'd2 || latch_en !== 1'b1 || phase !== 4'd0) begin mismatched++; $display("FAIL restart_run: got state=%0d latch=%0d phase=%0d expected 2/1/0", state, latch_en, phase); end
    for (int p = 0; p < 8; p++) step();
    compared++; if (frame_cnt !== 16'd1 || cluster_count !== 5'd0) begin mismatched++; $display("FAIL restart_frame: got frame_cnt=%0d cc=%0d expected 1/0", frame_cnt, cluster_count); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_startup();
    test_cluster_count();
    test_overflow();
    test_resync();
    test_resync_at_frame_end();
    test_disable_priority();
    test_delay_resync();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
